// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register FunSel encodings and the byte-pair loader state set.
package cpu_pkg;

   localparam logic [1:0] FUNSEL_DEC  = 2'b00;
   localparam logic [1:0] FUNSEL_INC  = 2'b01;
   localparam logic [1:0] FUNSEL_LOAD = 2'b10;
   localparam logic [1:0] FUNSEL_CLR  = 2'b11;

   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_RD_A_ENC  = 3'd1;
   localparam logic [2:0] ST_RD_B_ENC  = 3'd2;
   localparam logic [2:0] ST_CAP_ENC   = 3'd3;
   localparam logic [2:0] ST_WRITE_ENC = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE_ENC,
      RD_A  = ST_RD_A_ENC,
      RD_B  = ST_RD_B_ENC,
      CAP   = ST_CAP_ENC,
      WRITE = ST_WRITE_ENC
   } loader_state_e;

endpackage

// File: rtl/byte_pair_loader.sv
// Fetches two consecutive bytes from synchronous-read memory and loads the
// assembled 16-bit word into a Register16bit-class target in one cycle.
module byte_pair_loader
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [7:0]        MemData,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRead,
   output logic [15:0]       RegI,
   output logic [1:0]        RegFunSel,
   output logic              RegE,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] NextAddr
);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [ADDR_W-1:0] memaddr_q, memaddr_d;
   logic [ADDR_W-1:0] next_q, next_d;
   logic [7:0]        byte0_q, byte0_d;
   logic [15:0]       regi_q, regi_d;

   logic              accept;
   logic [ADDR_W-1:0] add_op;
   logic [ADDR_W-1:0] add_inc;
   logic [ADDR_W-1:0] sum;

   // One shared adder: BaseAddr+2 on accept, A+1 in RD_A (never both at once).
   always_comb begin
      accept  = Start && ((state_q == IDLE) || (state_q == WRITE));
      add_op  = accept ? BaseAddr : a_q;
      add_inc = accept ? ADDR_W'(2) : ADDR_W'(1);
      sum     = add_op + add_inc;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      memaddr_d = memaddr_q;
      next_d    = next_q;
      byte0_d   = byte0_q;
      regi_d    = regi_q;
      case (state_q)
         IDLE, WRITE: begin
            if (accept) begin
               a_d       = BaseAddr;
               next_d    = sum;
               memaddr_d = BaseAddr;
               state_d   = RD_A;
            end else begin
               state_d   = IDLE;
            end
         end
         RD_A: begin
            memaddr_d = sum;
            state_d   = RD_B;
         end
         RD_B: begin
            byte0_d = MemData;
            state_d = CAP;
         end
         CAP: begin
            regi_d  = BIG_ENDIAN ? {byte0_q, MemData} : {MemData, byte0_q};
            state_d = WRITE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         memaddr_q <= '0;
         next_q    <= '0;
         byte0_q   <= '0;
         regi_q    <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         memaddr_q <= memaddr_d;
         next_q    <= next_d;
         byte0_q   <= byte0_d;
         regi_q    <= regi_d;
      end
   end

   always_comb begin
      MemAddr   = memaddr_q;
      MemRead   = (state_q == RD_A) || (state_q == RD_B);
      RegI      = regi_q;
      RegFunSel = FUNSEL_LOAD;
      RegE      = (state_q == WRITE);
      Done      = (state_q == WRITE);
      Busy      = (state_q != IDLE);
      NextAddr  = next_q;
   end

endmodule
